// File: rtl/jtag_tap_target_pkg.sv
// Shared JTAG definitions: instruction opcodes, TAP state encoding, DR select
// and the pattern the IR captures.
package JtagGlobalPkg;

   typedef enum logic [4:0] {
      bypassRegister        = 5'b00000,
      userDefinedRegister   = 5'b00001,
      boundaryScanRegisters = 5'b00010,
      jtagIdcodeRegister    = 5'b00011
   } JtagInstructionOpcodeEnum;

   // Encoding is fixed by declaration order: reset is 0, UpdateDr is 15.
   typedef enum logic [3:0] {
      jtagResetState,
      jtagIdleState,
      jtagDrScanState,
      jtagIrScanState,
      jtagCaptureIrState,
      jtagShiftIrState,
      jtagExit1IrState,
      jtagPauseIrState,
      jtagExit2IrState,
      jtagUpdateIrState,
      jtagCaptureDrState,
      jtagShiftDrState,
      jtagExit1DrState,
      jtagPauseDrState,
      jtagExit2DrState,
      jtagUpdateDrState
   } JtagTapStates;

   typedef enum logic [1:0] {
      selBypass,
      selUser,
      selBoundary,
      selIdcode
   } JtagDrSelect;

   // IR capture pattern: LSB set, everything else clear.
   localparam logic [4:0] IR_CAPTURE_VALUE = 5'b00001;
   localparam int         IDCODE_WIDTH     = 32;

endpackage

// File: rtl/jtag_tap_target_fsm.sv
// 16-state TAP controller: next-state logic and the registered state.
module jtag_tap_fsm
   import JtagGlobalPkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       tms,
   output logic [3:0] tapState
);

   JtagTapStates state;

   assign tapState = state;

   // Advance the TAP state on every rising edge, steered by tms.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= jtagResetState;
      end else begin
         case (state)
            jtagResetState:     state <= tms ? jtagResetState    : jtagIdleState;
            jtagIdleState:      state <= tms ? jtagDrScanState   : jtagIdleState;
            jtagDrScanState:    state <= tms ? jtagIrScanState   : jtagCaptureDrState;
            jtagIrScanState:    state <= tms ? jtagResetState    : jtagCaptureIrState;
            jtagCaptureIrState: state <= tms ? jtagExit1IrState  : jtagShiftIrState;
            jtagShiftIrState:   state <= tms ? jtagExit1IrState  : jtagShiftIrState;
            jtagExit1IrState:   state <= tms ? jtagUpdateIrState : jtagPauseIrState;
            jtagPauseIrState:   state <= tms ? jtagExit2IrState  : jtagPauseIrState;
            jtagExit2IrState:   state <= tms ? jtagUpdateIrState : jtagShiftIrState;
            jtagUpdateIrState:  state <= tms ? jtagDrScanState   : jtagIdleState;
            jtagCaptureDrState: state <= tms ? jtagExit1DrState  : jtagShiftDrState;
            jtagShiftDrState:   state <= tms ? jtagExit1DrState  : jtagShiftDrState;
            jtagExit1DrState:   state <= tms ? jtagUpdateDrState : jtagPauseDrState;
            jtagPauseDrState:   state <= tms ? jtagExit2DrState  : jtagPauseDrState;
            jtagExit2DrState:   state <= tms ? jtagUpdateDrState : jtagShiftDrState;
            jtagUpdateDrState:  state <= tms ? jtagDrScanState   : jtagIdleState;
            default:            state <= jtagResetState;
         endcase
      end
   end

endmodule

// File: rtl/jtag_tap_target.sv
// Target-side JTAG TAP: IR plus bypass/user/boundary/IDCODE data registers.
module jtag_tap_target
   import JtagGlobalPkg::*;
#(
   parameter int          INSTRUCTION_WIDTH   = 5,
   parameter int          TEST_VECTOR_WIDTH   = 32,
   parameter int          BOUNDARY_SCAN_WIDTH = 16,
   parameter logic [31:0] IDCODE_VALUE        = 32'h1000_0001
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           tms,
   input  logic                           tdi,
   output logic                           tdo,
   output logic                           tdoEnable,
   output logic [3:0]                     tapState,
   output logic [INSTRUCTION_WIDTH-1:0]   instruction,
   input  logic [TEST_VECTOR_WIDTH-1:0]   userDataIn,
   output logic [TEST_VECTOR_WIDTH-1:0]   userDataOut,
   input  logic [BOUNDARY_SCAN_WIDTH-1:0] boundaryIn,
   output logic [BOUNDARY_SCAN_WIDTH-1:0] boundaryOut,
   output logic                           updateStrobe
);

   localparam logic [INSTRUCTION_WIDTH-1:0] OP_USER     = INSTRUCTION_WIDTH'(userDefinedRegister);
   localparam logic [INSTRUCTION_WIDTH-1:0] OP_BOUNDARY = INSTRUCTION_WIDTH'(boundaryScanRegisters);
   localparam logic [INSTRUCTION_WIDTH-1:0] OP_IDCODE   = INSTRUCTION_WIDTH'(jtagIdcodeRegister);

   JtagTapStates                   state;
   JtagDrSelect                    drSel;
   logic [INSTRUCTION_WIDTH-1:0]   irShift;
   logic                           bypassShift;
   logic [TEST_VECTOR_WIDTH-1:0]   userShift;
   logic [BOUNDARY_SCAN_WIDTH-1:0] boundaryShift;
   logic [IDCODE_WIDTH-1:0]        idcodeShift;

   jtag_tap_fsm uFsm (
      .clk      (clk),
      .reset    (reset),
      .tms      (tms),
      .tapState (tapState)
   );

   assign state        = JtagTapStates'(tapState);
   assign tdoEnable    = (state == jtagShiftIrState) || (state == jtagShiftDrState);
   assign updateStrobe = (state == jtagUpdateDrState);

   // Unknown opcodes fall back to bypass.
   always_comb begin
      drSel = selBypass;
      if (instruction == OP_USER)          drSel = selUser;
      else if (instruction == OP_BOUNDARY) drSel = selBoundary;
      else if (instruction == OP_IDCODE)   drSel = selIdcode;
   end

   // IR capture/shift/update; the instruction is held at bypass while in reset state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irShift     <= '0;
         instruction <= '0;
      end else begin
         case (state)
            jtagResetState:     instruction <= '0;
            jtagCaptureIrState: irShift     <= INSTRUCTION_WIDTH'(IR_CAPTURE_VALUE);
            jtagShiftIrState:   irShift     <= {tdi, irShift[INSTRUCTION_WIDTH-1:1]};
            jtagUpdateIrState:  instruction <= irShift;
            default: ;
         endcase
      end
   end

   // DR capture/shift for the selected register, parallel update on leaving UpdateDr.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bypassShift   <= 1'b0;
         userShift     <= '0;
         boundaryShift <= '0;
         idcodeShift   <= '0;
         userDataOut   <= '0;
         boundaryOut   <= '0;
      end else begin
         case (state)
            jtagCaptureDrState: begin
               case (drSel)
                  selBypass:   bypassShift   <= 1'b0;
                  selUser:     userShift     <= userDataIn;
                  selBoundary: boundaryShift <= boundaryIn;
                  selIdcode:   idcodeShift   <= IDCODE_VALUE;
                  default: ;
               endcase
            end
            jtagShiftDrState: begin
               case (drSel)
                  selBypass:   bypassShift   <= tdi;
                  selUser:     userShift     <= {tdi, userShift[TEST_VECTOR_WIDTH-1:1]};
                  // Shift form that also holds for a 1-bit boundary chain.
                  selBoundary: boundaryShift <= (boundaryShift >> 1)
                                              | (BOUNDARY_SCAN_WIDTH'(tdi) << (BOUNDARY_SCAN_WIDTH-1));
                  selIdcode:   idcodeShift   <= {tdi, idcodeShift[IDCODE_WIDTH-1:1]};
                  default: ;
               endcase
            end
            jtagUpdateDrState: begin
               if (drSel == selUser)     userDataOut <= userShift;
               if (drSel == selBoundary) boundaryOut <= boundaryShift;
            end
            default: ;
         endcase
      end
   end

   // tdo carries the LSB of whichever register is shifting, else 0.
   always_comb begin
      tdo = 1'b0;
      if (state == jtagShiftIrState) begin
         tdo = irShift[0];
      end else if (state == jtagShiftDrState) begin
         case (drSel)
            selBypass:   tdo = bypassShift;
            selUser:     tdo = userShift[0];
            selBoundary: tdo = boundaryShift[0];
            selIdcode:   tdo = idcodeShift[0];
            default:     tdo = 1'b0;
         endcase
      end
   end

endmodule
